// File: rtl/trng_pkg.sv
// trng_pkg: state encoding, default parameters and a state helper
// shared by the TRNG collector and its health-test block.
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    COLLECT = 2'd2,
    FAIL    = 2'd3
  } trng_state_e;

  localparam int DEF_WORD_W     = 32;
  localparam int DEF_WARM_BITS  = 64;
  localparam int DEF_RCT_CUTOFF = 31;
  localparam int DEF_APT_WIN    = 512;
  localparam int DEF_APT_CUTOFF = 410;

  // Source running and bits being health-tested.
  function automatic logic is_active(trng_state_e s);
    return (s == WARMUP) || (s == COLLECT);
  endfunction

endpackage

// File: rtl/trng_collector_health.sv
// trng_health: repetition-count and adaptive-proportion tests on raw bits.
// Ports: clk, rst (async high), clear, bit_vld, bit_in -> rct_fail, apt_fail.
module trng_health
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
  parameter int APT_WIN    = DEF_APT_WIN,
  parameter int APT_CUTOFF = DEF_APT_CUTOFF
)(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic bit_vld,
  input  logic bit_in,
  output logic rct_fail,
  output logic apt_fail
);

  localparam int AW = $clog2(APT_WIN);
  localparam int AC = AW + 1;

  logic [7:0]    rct_cnt_q, rct_cnt_d;
  logic          rct_last_q, rct_last_d;
  logic          rct_fail_q, rct_fail_d;
  logic [AW-1:0] apt_pos_q, apt_pos_d;
  logic [AC-1:0] apt_cnt_q, apt_cnt_d;
  logic          apt_ref_q, apt_ref_d;
  logic          apt_fail_q, apt_fail_d;

  always_comb begin
    rct_cnt_d  = rct_cnt_q;
    rct_last_d = rct_last_q;
    rct_fail_d = rct_fail_q;
    apt_pos_d  = apt_pos_q;
    apt_cnt_d  = apt_cnt_q;
    apt_ref_d  = apt_ref_q;
    apt_fail_d = apt_fail_q;
    if (clear) begin
      rct_cnt_d  = '0;
      rct_last_d = 1'b0;
      rct_fail_d = 1'b0;
      apt_pos_d  = '0;
      apt_cnt_d  = '0;
      apt_ref_d  = 1'b0;
      apt_fail_d = 1'b0;
    end else if (bit_vld) begin
      // Run length; a zero count means no bit seen since clear.
      rct_last_d = bit_in;
      if (rct_cnt_q != 8'd0 && bit_in == rct_last_q) begin
        if (rct_cnt_q != 8'hFF)
          rct_cnt_d = rct_cnt_q + 8'd1;
      end else begin
        rct_cnt_d = 8'd1;
      end
      if (rct_cnt_d == 8'(RCT_CUTOFF))
        rct_fail_d = 1'b1;
      // Window position wraps at APT_WIN; position 0 latches the reference.
      apt_pos_d = apt_pos_q + AW'(1);
      if (apt_pos_q == '0) begin
        apt_ref_d = bit_in;
        apt_cnt_d = AC'(1);
      end else if (bit_in == apt_ref_q) begin
        apt_cnt_d = apt_cnt_q + AC'(1);
      end
      if (apt_cnt_d == AC'(APT_CUTOFF))
        apt_fail_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rct_cnt_q  <= '0;
      rct_last_q <= 1'b0;
      rct_fail_q <= 1'b0;
      apt_pos_q  <= '0;
      apt_cnt_q  <= '0;
      apt_ref_q  <= 1'b0;
      apt_fail_q <= 1'b0;
    end else begin
      rct_cnt_q  <= rct_cnt_d;
      rct_last_q <= rct_last_d;
      rct_fail_q <= rct_fail_d;
      apt_pos_q  <= apt_pos_d;
      apt_cnt_q  <= apt_cnt_d;
      apt_ref_q  <= apt_ref_d;
      apt_fail_q <= apt_fail_d;
    end
  end

  assign rct_fail = rct_fail_q;
  assign apt_fail = apt_fail_q;

endmodule

// File: rtl/trng_collector.sv
// trng_collector: enables the TRNG source, synchronises and health-tests
// its bits, and packs them MSB-first into WORD_W-bit words for the crypto
// core. Ports: clk, rst (async high), en, rnd_bit, clr_fail, rready in;
// trng_en, rdata, rvalid, health_fail out.
// Optional macro TRNG_VN_DEBIAS_EN inserts a Von Neumann debiaser
// between the health tests and the packer.
module trng_collector
  import trng_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int WARM_BITS  = DEF_WARM_BITS,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
  parameter int APT_WIN    = DEF_APT_WIN,
  parameter int APT_CUTOFF = DEF_APT_CUTOFF
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rnd_bit,
  output logic              trng_en,
  output logic [WORD_W-1:0] rdata,
  output logic              rvalid,
  input  logic              rready,
  output logic              health_fail,
  input  logic              clr_fail
);

  localparam int CW = $clog2(WORD_W + 1);
  localparam int WW = $clog2(WARM_BITS + 1);

  trng_state_e       state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [WW-1:0]     warm_q, warm_d;
  logic              pk_vld_q, pk_vld_d;
  logic              pk_bit_q, pk_bit_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              trng_en_q, trng_en_d;
  logic              hfail_q, hfail_d;
  logic              rct_fail, apt_fail;
  logic              fail, full, take;
`ifdef TRNG_VN_DEBIAS_EN
  logic              pair_ph_q, pair_ph_d;
  logic              pair_bit_q, pair_bit_d;
`endif

  assign fail = rct_fail | apt_fail;
  assign sync_d = {sync_q[0], rnd_bit};

  // Counters sit cleared outside WARMUP/COLLECT, so entry starts fresh.
  trng_health #(
    .RCT_CUTOFF (RCT_CUTOFF),
    .APT_WIN    (APT_WIN),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_health (
    .clk      (clk),
    .rst      (rst),
    .clear    (!is_active(state_q)),
    .bit_vld  (is_active(state_q)),
    .bit_in   (sync_q[1]),
    .rct_fail (rct_fail),
    .apt_fail (apt_fail)
  );

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    unique case (state_q)
      IDLE: begin
        if (en)
          state_d = WARMUP;
      end
      WARMUP: begin
        warm_d = warm_q + WW'(1);
        if (fail)
          state_d = FAIL;
        else if (!en)
          state_d = IDLE;
        else if (warm_q == WW'(WARM_BITS - 1))
          state_d = COLLECT;
      end
      COLLECT: begin
        if (fail)
          state_d = FAIL;
        else if (!en)
          state_d = IDLE;
      end
      FAIL: begin
        if (clr_fail)
          state_d = en ? WARMUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != WARMUP)
      warm_d = '0;
    trng_en_d = is_active(state_d);
    hfail_d   = (state_d == FAIL);
  end

  // Packer input stage: one register between the synchroniser and the
  // shift register, which doubles as the debiaser's output register.
  always_comb begin
    pk_vld_d = 1'b0;
    pk_bit_d = sync_q[1];
`ifdef TRNG_VN_DEBIAS_EN
    pair_ph_d  = 1'b0;
    pair_bit_d = pair_bit_q;
    if (state_q == COLLECT) begin
      pair_ph_d = ~pair_ph_q;
      if (!pair_ph_q) begin
        pair_bit_d = sync_q[1];
      end else begin
        pk_vld_d = (pair_bit_q != sync_q[1]);
        pk_bit_d = pair_bit_q;
      end
    end
`else
    pk_vld_d = (state_q == COLLECT);
`endif
  end

  assign full = (cnt_q == CW'(WORD_W));
  assign take = pk_vld_q && (state_q == COLLECT);

  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    if (rvalid_q && rready)
      rvalid_d = 1'b0;
    if (full && (!rvalid_q || rready)) begin
      // Hand over and keep the incoming bit as the new word's first bit.
      rdata_d  = shift_q;
      rvalid_d = 1'b1;
      shift_d  = take ? {{(WORD_W-1){1'b0}}, pk_bit_q} : '0;
      cnt_d    = take ? CW'(1) : '0;
    end else if (!full && take) begin
      shift_d = {shift_q[WORD_W-2:0], pk_bit_q};
      cnt_d   = cnt_q + CW'(1);
    end
    if (state_d != COLLECT) begin
      shift_d = '0;
      cnt_d   = '0;
    end
    // A word collected before a failure is no longer trusted.
    if (state_d == FAIL) begin
      rdata_d  = '0;
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      warm_q    <= '0;
      pk_vld_q  <= 1'b0;
      pk_bit_q  <= 1'b0;
      shift_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      trng_en_q <= 1'b0;
      hfail_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      warm_q    <= warm_d;
      pk_vld_q  <= pk_vld_d;
      pk_bit_q  <= pk_bit_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      trng_en_q <= trng_en_d;
      hfail_q   <= hfail_d;
    end
  end

`ifdef TRNG_VN_DEBIAS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_ph_q  <= 1'b0;
      pair_bit_q <= 1'b0;
    end else begin
      pair_ph_q  <= pair_ph_d;
      pair_bit_q <= pair_bit_d;
    end
  end
`endif

  assign trng_en     = trng_en_q;
  assign rdata       = rdata_q;
  assign rvalid      = rvalid_q;
  assign health_fail = hfail_q;

endmodule
